// File: rtl/pipelined_addsub_acc.sv
// pipelined_addsub_acc
//   Pipelined add / subtract / accumulate / load-accumulator unit with
//   valid/ready handshakes on both sides. The result is computed in the
//   accept cycle and then carried through LATENCY result registers.
//   The accumulator updates at accept time, so back-to-back accumulates
//   chain without hazard.
//
// Parameters
//   WIDTH   operand width (2..32)
//   LATENCY register stages from accept to out_valid (1..4)
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   in_valid / in_ready input handshake (in_ready is combinational from out_ready)
//   op                  00 add, 01 sub, 10 accumulate, 11 load accumulator
//   a, b                operands (b unused for op 10/11)
//   out_valid/out_ready output handshake
//   y                   WIDTH+1 result, top bit is carry (add/acc) or borrow (sub)
//   ovf                 two's-complement overflow of the WIDTH-bit result
//   acc_out             accumulator value, updated at accept
module pipelined_addsub_acc #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   y,
  output logic             ovf,
  output logic [WIDTH-1:0] acc_out
);

  localparam int MSB = WIDTH - 1;

  typedef struct packed {
    logic           ovf;
    logic [WIDTH:0] y;
  } res_t;

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH:0]   sum;
  logic             ovf_c;
  logic             advance;

  logic [LATENCY:1] vld_pipe;
  res_t             res_pipe [1:LATENCY];

  // The whole pipeline moves together; a held output freezes every stage,
  // so bubbles are kept rather than squeezed out.
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[LATENCY];
  assign y         = res_pipe[LATENCY].y;
  assign ovf       = res_pipe[LATENCY].ovf;
  assign acc_out   = acc_q;

  // Accept-stage arithmetic. The zero-extended subtraction leaves the
  // borrow in sum[WIDTH] (set iff a < b unsigned).
  always_comb begin
    sum   = {1'b0, a};
    ovf_c = 1'b0;
    case (op)
      2'b00: begin
        sum   = {1'b0, a} + {1'b0, b};
        ovf_c = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      2'b01: begin
        sum   = {1'b0, a} - {1'b0, b};
        ovf_c = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
      end
      2'b10: begin
        sum   = {1'b0, acc_q} + {1'b0, a};
        ovf_c = (acc_q[MSB] == a[MSB]) && (sum[MSB] != acc_q[MSB]);
      end
      default: begin
        sum   = {1'b0, a};
        ovf_c = 1'b0;
      end
    endcase
  end

  // Accumulator wraps modulo 2^WIDTH; carry is visible only in y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc_q <= '0;
    else if (in_valid && advance && op[1])
      acc_q <= sum[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 1; i <= LATENCY; i++) res_pipe[i] <= '0;
    end else if (advance) begin
      vld_pipe[1] <= in_valid;
      res_pipe[1] <= {ovf_c, sum};
      for (int i = 2; i <= LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        res_pipe[i] <= res_pipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub_acc.sv
// Bench for pipelined_addsub_acc: four instances (W8/L2, W8/L1, W8/L4,
// W4/L2) share op/a/b/out_ready; each has its own in_valid so an
// operation is offered until every instance has taken it. Expected
// results are pushed per instance at accept and popped at output.
module tb_pipelined_addsub_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] in_valid_v;
  logic [1:0] op;
  logic [7:0] a, b;
  logic       out_ready;
  wire  [3:0] in_ready_v, out_valid_v, ovf_v;
  wire  [8:0] y_v   [4];
  wire  [7:0] acc_v [4];
  wire  [4:0] y4;
  wire  [3:0] acc4;

  pipelined_addsub_acc #(.WIDTH(8), .LATENCY(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .op(op), .a(a), .b(b), .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .y(y_v[0]), .ovf(ovf_v[0]), .acc_out(acc_v[0]));
  pipelined_addsub_acc #(.WIDTH(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .op(op), .a(a), .b(b), .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .y(y_v[1]), .ovf(ovf_v[1]), .acc_out(acc_v[1]));
  pipelined_addsub_acc #(.WIDTH(8), .LATENCY(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .op(op), .a(a), .b(b), .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .y(y_v[2]), .ovf(ovf_v[2]), .acc_out(acc_v[2]));
  pipelined_addsub_acc #(.WIDTH(4), .LATENCY(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
    .op(op), .a(a[3:0]), .b(b[3:0]), .out_valid(out_valid_v[3]), .out_ready(out_ready),
    .y(y4), .ovf(ovf_v[3]), .acc_out(acc4));
  assign y_v[3]   = {4'b0, y4};
  assign acc_v[3] = {4'b0, acc4};

  function automatic int wof(input int g);
    return (g == 3) ? 4 : 8;
  endfunction
  function automatic int lof(input int g);
    return (g == 1) ? 1 : (g == 2) ? 4 : 2;
  endfunction

  // Expected value encoding: {ovf, y[8:0]}
  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [9:0] e8;
    logic [9:0] e4;
  } vec_t;
  vec_t tab [12];

  int         n_run, n_fail, cyc, st_lo, st_hi;
  logic [9:0] sbq [4][$];
  logic [7:0] acc_m [4];
  int         out_cnt [4];
  bit         was_stall [4];
  logic [8:0] py [4];
  logic       pov [4];
  logic [3:0] pend;
  bit         cur_tv, rnd_rdy;
  logic [9:0] cur_e8, cur_e4;

  task automatic chk(input bit ok, input string nm, input int g,
                     input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s dut%0d got=%0h want=%0h", nm, g, act, exp);
    end
  endtask

  // Reference model from signed/unsigned integer arithmetic.
  function automatic logic [9:0] model(input int w, input logic [1:0] o,
      input logic [7:0] a8, input logic [7:0] b8, input logic [7:0] c8,
      output logic [7:0] acc_new);
    int m, half, ai, bi, ci, sa, sb, sc, s, sr;
    logic [9:0] r;
    m = (1 << w) - 1; half = 1 << (w - 1);
    ai = int'(a8) & m; bi = int'(b8) & m; ci = int'(c8) & m;
    sa = (ai >= half) ? ai - (1 << w) : ai;
    sb = (bi >= half) ? bi - (1 << w) : bi;
    sc = (ci >= half) ? ci - (1 << w) : ci;
    case (o)
      2'd0:    begin s = ai + bi; sr = sa + sb; end
      2'd1:    begin s = ai - bi; sr = sa - sb; end
      2'd2:    begin s = ci + ai; sr = sc + sa; end
      default: begin s = ai;      sr = sa;      end
    endcase
    r[8:0] = 9'(s & ((1 << (w + 1)) - 1));
    r[9]   = (sr > half - 1) || (sr < -half);
    acc_new = o[1] ? 8'(s & m) : c8;
    return r;
  endfunction

  // One clock: sample handshakes just before the edge, then step past it.
  task automatic step();
    logic [9:0] e;
    logic [7:0] an;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    else         out_ready = !(cyc >= st_lo && cyc <= st_hi);
    #1;
    for (int g = 0; g < 4; g++) begin
      if (was_stall[g])
        chk(out_valid_v[g] && y_v[g] == py[g] && ovf_v[g] == pov[g], "stall_hold", g,
            {22'b0, ovf_v[g], y_v[g]}, {22'b0, pov[g], py[g]});
      if (out_valid_v[g] && !out_ready)
        chk(!in_ready_v[g], "in_ready_stall", g, 32'(in_ready_v[g]), 0);
      if (in_valid_v[g] && in_ready_v[g]) begin
        e = model(wof(g), op, a, b, acc_m[g], an);
        if (cur_tv) e = (wof(g) == 8) ? cur_e8 : cur_e4;
        sbq[g].push_back(e);
        acc_m[g] = an;
        pend[g]  = 1'b0;
      end
      if (out_valid_v[g] && out_ready) begin
        out_cnt[g]++;
        if (sbq[g].size() == 0)
          chk(0, "unexpected_out", g, {22'b0, ovf_v[g], y_v[g]}, 0);
        else begin
          e = sbq[g].pop_front();
          chk({ovf_v[g], y_v[g]} == e, "result", g, {22'b0, ovf_v[g], y_v[g]}, {22'b0, e});
        end
      end
      was_stall[g] = out_valid_v[g] && !out_ready;
      py[g]  = y_v[g];
      pov[g] = ovf_v[g];
    end
    @(posedge clk); #1;
    cyc++;
    for (int g = 0; g < 4; g++)
      chk(acc_v[g] == acc_m[g], "acc_out", g, 32'(acc_v[g]), 32'(acc_m[g]));
    in_valid_v = pend;
  endtask

  task automatic send(input logic [1:0] o, input logic [7:0] x, input logic [7:0] z,
                      input bit tv);
    int n;
    cur_tv = tv; op = o; a = x; b = z;
    pend = 4'hF; in_valid_v = pend; n = 0;
    while (pend != 0 && n < 60) begin step(); n++; end
    if (pend != 0) begin
      chk(0, "accept_timeout", 0, 32'(pend), 0);
      pend = 0; in_valid_v = 0;
    end
    cur_tv = 0;
  endtask

  function automatic bit busy();
    for (int g = 0; g < 4; g++)
      if (out_valid_v[g] || sbq[g].size() != 0) return 1;
    return 0;
  endfunction

  task automatic drain();
    int n = 0;
    while (busy() && n < 80) begin step(); n++; end
    for (int g = 0; g < 4; g++)
      chk(sbq[g].size() == 0 && !out_valid_v[g], "drain", g, sbq[g].size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat [4];
    int cnt0 [4];
    rst_n = 1'b0; in_valid_v = 0; op = 0; a = 0; b = 0; out_ready = 1'b1;
    cur_tv = 0; rnd_rdy = 0; st_lo = 1; st_hi = 0; cyc = 0; pend = 0;
    n_run = 0; n_fail = 0; cur_e8 = 0; cur_e4 = 0;
    for (int g = 0; g < 4; g++) begin
      acc_m[g] = 0; out_cnt[g] = 0; was_stall[g] = 0; py[g] = 0; pov[g] = 0;
    end

    tab[0]  = '{2'd0, 8'd255,  8'd1,  10'h100, 10'h010};
    tab[1]  = '{2'd0, 8'd127,  8'd1,  10'h280, 10'h010};
    tab[2]  = '{2'd1, 8'd5,    8'd3,  10'h002, 10'h002};
    tab[3]  = '{2'd1, 8'd3,    8'd5,  10'h1FE, 10'h01E};
    tab[4]  = '{2'd1, 8'h80,   8'd1,  10'h27F, 10'h01F};
    tab[5]  = '{2'd3, 8'd250,  8'd0,  10'h0FA, 10'h00A};
    tab[6]  = '{2'd2, 8'd3,    8'd0,  10'h0FD, 10'h00D};
    tab[7]  = '{2'd2, 8'd3,    8'd0,  10'h100, 10'h010};
    tab[8]  = '{2'd2, 8'd1,    8'd0,  10'h001, 10'h001};
    tab[9]  = '{2'd0, 8'd15,   8'd15, 10'h01E, 10'h01E};
    tab[10] = '{2'd0, 8'h40,   8'h40, 10'h280, 10'h000};
    tab[11] = '{2'd0, 8'd7,    8'd1,  10'h008, 10'h208};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) begin
      chk(!out_valid_v[g], "rst_out_valid", g, 32'(out_valid_v[g]), 0);
      chk(y_v[g] == 0 && !ovf_v[g], "rst_y", g, {22'b0, ovf_v[g], y_v[g]}, 0);
      chk(acc_v[g] == 0, "rst_acc", g, 32'(acc_v[g]), 0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk(in_ready_v == 4'hF, "rst_in_ready", 0, 32'(in_ready_v), 32'hF);

    // Table vectors, streamed back-to-back
    for (int i = 0; i < 12; i++) begin
      cur_e8 = tab[i].e8; cur_e4 = tab[i].e4;
      send(tab[i].op, tab[i].a, tab[i].b, 1);
      if (i == 8) chk(acc_v[0] == 8'h01, "acc_chain_end", 0, 32'(acc_v[0]), 32'h01);
    end
    drain();

    // Latency from an empty pipe
    cur_e8 = 10'h100; cur_e4 = 10'h010;
    send(2'd0, 8'd255, 8'd1, 1);
    for (int g = 0; g < 4; g++) lat[g] = -1;
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < 4; g++)
        if (lat[g] < 0 && out_valid_v[g]) lat[g] = k;
      step();
    end
    for (int g = 0; g < 4; g++)
      chk(lat[g] == lof(g) - 1, "latency", g, lat[g], lof(g) - 1);
    drain();

    // Six adds with the consumer stalled for three cycles
    for (int g = 0; g < 4; g++) cnt0[g] = out_cnt[g];
    st_lo = cyc + 3; st_hi = cyc + 5;
    for (int i = 0; i < 6; i++)
      send(2'd0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);
    drain();
    st_lo = 1; st_hi = 0;
    for (int g = 0; g < 4; g++)
      chk(out_cnt[g] - cnt0[g] == 6, "stall_count", g, out_cnt[g] - cnt0[g], 6);

    // Asynchronous reset with operations in flight
    send(2'd3, 8'h40, 8'd0, 0);
    send(2'd0, 8'd1, 8'd2, 0);
    send(2'd0, 8'd3, 8'd4, 0);
    chk(out_valid_v[0] && acc_v[0] == 8'h40, "pre_rst_inflight", 0,
        {23'b0, out_valid_v[0], acc_v[0]}, 32'h140);
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 4; g++) begin
      chk(!out_valid_v[g], "async_rst_valid", g, 32'(out_valid_v[g]), 0);
      chk(acc_v[g] == 0, "async_rst_acc", g, 32'(acc_v[g]), 0);
      sbq[g].delete(); acc_m[g] = 0; was_stall[g] = 0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk(in_ready_v == 4'hF, "post_rst_in_ready", 0, 32'(in_ready_v), 32'hF);
    cur_e8 = 10'h002; cur_e4 = 10'h002;
    send(2'd0, 8'd1, 8'd1, 1);
    drain();

    // Random ops with random backpressure
    rnd_rdy = 1;
    for (int i = 0; i < 40; i++)
      send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);
    rnd_rdy = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
